smc_access_ctrl: RTL and testbench
==================================

SMC_ACCESS_CTRL -- requirements
Module: smc_access_ctrl

Interface
REQ-001 Parameter: AW, 32, address width.
REQ-002 Parameter: ENC_TIMEOUT, 64, max cycles to wait for enc_ack (1..255).
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 cfg_start  in  1  one-cycle pulse from l.start, load new SMC bounds.
REQ-006 cfg_stack_top  in  AW  stack top, becomes high bound.
REQ-007 cfg_heap_top  in  AW  heap top, becomes low bound.
REQ-008 cfg_clear  in  1  one-cycle pulse, deactivate SMC.
REQ-009 mem_req  in  1  CPU data access request, held until mem_ack.
REQ-010 mem_addr  in  AW  virtual address of access.
REQ-011 mem_we  in  1  access is a write.
REQ-012 mem_stall  out  1  CPU must hold pipeline.
REQ-013 mem_ack  out  1  one-cycle completion pulse.
REQ-014 mem_hit  out  1  valid with mem_ack; access was inside SMC.
REQ-015 mem_err  out  1  valid with mem_ack; encryption timed out.
REQ-016 enc_req  out  1  request to cache-line encryption engine.
REQ-017 enc_addr  out  AW  registered address for encryption.
REQ-018 enc_we  out  1  registered write flag for encryption.
REQ-019 enc_ack  in  1  engine done, single-cycle pulse.
REQ-020 low_bound, high_bound  out  AW each  current bounds.
REQ-021 smc_active  out  1  bounds valid, checking enabled.
REQ-022 err_cfg  out  1  one-cycle pulse, rejected configuration.

Function
REQ-023 FSM states: IDLE, CHECK, ENC, DONE.
REQ-024 IDLE: pending config applied first; else mem_req=1 registers mem_addr/mem_we and moves to CHECK.
REQ-025 CHECK (1 cycle): hit = smc_active and low_bound <= addr <= high_bound, unsigned, inclusive both ends; hit -> ENC, miss -> DONE.
REQ-026 ENC: enc_req=1 every cycle until enc_ack sampled high -> DONE; enc_addr/enc_we stable throughout.
REQ-027 ENC timeout: cycle counter cleared on ENC entry; ENC_TIMEOUT cycles without enc_ack -> DONE with mem_err=1, enc_req dropped.
REQ-028 enc_ack on the same cycle the counter expires: treated as success, mem_err=0.
REQ-029 DONE (1 cycle): mem_ack=1, mem_hit/mem_err driven, -> IDLE.
REQ-030 Latency: miss -> mem_ack 2 cycles after mem_req accepted; hit -> 3 + engine wait cycles.
REQ-031 mem_stall = mem_req in IDLE, 1 in CHECK/ENC, 0 in DONE.
REQ-032 enc_ack outside ENC ignored.
REQ-033 cfg_start/cfg_clear outside IDLE set a pending flag; applied on next IDLE cycle before any mem_req is accepted (mem_req then waits one cycle).
REQ-034 cfg_start: if cfg_heap_top <= cfg_stack_top, low/high bounds load, smc_active=1; else err_cfg pulse, bounds and smc_active unchanged.
REQ-035 Operand values used for pending cfg_start are those captured at the pulse.
REQ-036 cfg_clear and cfg_start together (or both pending): clear wins, smc_active=0, bounds unchanged.
REQ-037 Bound updates never affect an access already past IDLE.

Reset
REQ-038 rst_n low, any state: FSM -> IDLE, smc_active=0, bounds=0, pending flags=0, counter=0.
REQ-039 Outputs during reset: mem_stall=0 unless mem_req, mem_ack/mem_hit/mem_err/enc_req/err_cfg=0, enc_addr=0, enc_we=0.
REQ-040 Reset during ENC abandons the request; no mem_ack is issued for it.

Structure
REQ-041 Package smc_pkg: FSM state encoding, default AW and ENC_TIMEOUT constants.
REQ-042 One sub-module smc_range_cmp: combinational inclusive range compare (addr, low, high, enable -> hit), instantiated in CHECK path.

Verification
REQ-043 cfg_start heap=0x1000 stack=0x1FFF; reads 0x0FFF/0x1000/0x1FFF/0x2000 -> mem_hit 0,1,1,0; misses ack in 2 cycles.
REQ-044 Hit at 0x1800, mem_we=1, enc_ack after 5 cycles -> enc_req held 5 cycles, enc_addr=0x1800, enc_we=1, mem_ack hit=1 err=0.
REQ-045 ENC_TIMEOUT=8, no enc_ack -> enc_req 8 cycles, mem_ack with mem_err=1, next access proceeds normally.
REQ-046 cfg_start during ENC with new bounds 0x3000..0x3FFF -> current access uses old bounds; next access 0x3000 hits.
REQ-047 cfg_start heap=0x5000 stack=0x4000 -> err_cfg pulse, bounds unchanged; cfg_start+cfg_clear same cycle -> smc_active=0.
REQ-048 rst_n low mid-ENC -> all outputs reset values, no mem_ack, smc_active=0 after release.

Source files
------------

// File: rtl/smc_pkg.sv
// Shared types and default constants for the SMC access controller.
package smc_pkg;

    localparam int unsigned SMC_DEF_AW          = 32;
    localparam int unsigned SMC_DEF_ENC_TIMEOUT = 64;

    // Access FSM: accept in IDLE, range-check in CHECK, wait on engine in ENC, ack in DONE
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_ENC   = 2'd2,
        ST_DONE  = 2'd3
    } smc_state_t;

endpackage

// File: rtl/smc_access_ctrl_if.sv
// CPU data-access and encryption-engine handshake bundle.
interface smc_access_ctrl_if
    import smc_pkg::*;
#(
    parameter int unsigned AW = SMC_DEF_AW
);
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic          mem_stall;
    logic          mem_ack;
    logic          mem_hit;
    logic          mem_err;
    logic          enc_req;
    logic [AW-1:0] enc_addr;
    logic          enc_we;
    logic          enc_ack;

    modport slave (
        input  mem_req, mem_addr, mem_we, enc_ack,
        output mem_stall, mem_ack, mem_hit, mem_err, enc_req, enc_addr, enc_we
    );

    modport master (
        output mem_req, mem_addr, mem_we, enc_ack,
        input  mem_stall, mem_ack, mem_hit, mem_err, enc_req, enc_addr, enc_we
    );

endinterface

// File: rtl/smc_range_cmp.sv
// Inclusive unsigned range compare: hit when enabled and low <= addr <= high.
module smc_range_cmp #(
    parameter int unsigned AW = 32
) (
    input  logic [AW-1:0] i_addr,
    input  logic [AW-1:0] i_low,
    input  logic [AW-1:0] i_high,
    input  logic          i_en,
    output logic          o_hit
);

    // Both bounds are inclusive
    always_comb begin
        o_hit = i_en && (i_addr >= i_low) && (i_addr <= i_high);
    end

endmodule

// File: rtl/smc_access_ctrl.sv
// SMC access controller: range-checks CPU data accesses against the current
// bounds and routes in-range accesses through the cache-line encryption engine.
module smc_access_ctrl
    import smc_pkg::*;
#(
    parameter int unsigned AW          = SMC_DEF_AW,
    parameter int unsigned ENC_TIMEOUT = SMC_DEF_ENC_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_start,
    input  logic [AW-1:0] cfg_stack_top,
    input  logic [AW-1:0] cfg_heap_top,
    input  logic          cfg_clear,
    smc_access_ctrl_if.slave bus,
    output logic [AW-1:0] low_bound,
    output logic [AW-1:0] high_bound,
    output logic          smc_active,
    output logic          err_cfg
);

    localparam logic [7:0] LP_CNT_LAST = 8'(ENC_TIMEOUT - 1);

    smc_state_t    r_state;
    smc_state_t    w_state_nxt;

    logic [AW-1:0] r_low;
    logic [AW-1:0] r_high;
    logic          r_active;
    logic          r_err_cfg;
    logic          r_pend_start;
    logic          r_pend_clear;
    logic [AW-1:0] r_pend_heap;
    logic [AW-1:0] r_pend_stack;

    logic [AW-1:0] r_addr;
    logic          r_we;
    logic [7:0]    r_cnt;
    logic          r_hit;
    logic          r_err;

    logic          w_idle;
    logic          w_cfg_any;
    logic          w_do_clear;
    logic          w_do_start;
    logic [AW-1:0] w_st_heap;
    logic [AW-1:0] w_st_stack;
    logic          w_hit;
    logic          w_cnt_last;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_cfg_any  = cfg_start | cfg_clear | r_pend_start | r_pend_clear;
    assign w_do_clear = cfg_clear | r_pend_clear;
    assign w_do_start = cfg_start | r_pend_start;
    // A live pulse carries the newest operands; otherwise use the ones captured earlier
    assign w_st_heap  = cfg_start ? cfg_heap_top  : r_pend_heap;
    assign w_st_stack = cfg_start ? cfg_stack_top : r_pend_stack;
    assign w_cnt_last = (r_cnt == LP_CNT_LAST);

    // Bounds only change in IDLE, so the compare sees stable bounds for an in-flight access
    smc_range_cmp #(
        .AW(AW)
    ) u_range_cmp (
        .i_addr (r_addr),
        .i_low  (r_low),
        .i_high (r_high),
        .i_en   (r_active),
        .o_hit  (w_hit)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; pending configuration holds off access acceptance for a cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (!w_cfg_any && bus.mem_req) w_state_nxt = ST_CHECK;
            ST_CHECK: w_state_nxt = w_hit ? ST_ENC : ST_DONE;
            ST_ENC:   if (bus.enc_ack || w_cnt_last) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from state and registered access data
    always_comb begin
        bus.mem_stall = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_hit   = 1'b0;
        bus.mem_err   = 1'b0;
        bus.enc_req   = 1'b0;
        bus.enc_addr  = r_addr;
        bus.enc_we    = r_we;
        case (r_state)
            ST_IDLE:  bus.mem_stall = bus.mem_req;
            ST_CHECK: bus.mem_stall = 1'b1;
            ST_ENC: begin
                bus.mem_stall = 1'b1;
                bus.enc_req   = 1'b1;
            end
            ST_DONE: begin
                bus.mem_ack = 1'b1;
                bus.mem_hit = r_hit;
                bus.mem_err = r_err;
            end
            default: ;
        endcase
    end

    // Access datapath: capture request, record hit, run the engine timeout counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_we   <= 1'b0;
            r_cnt  <= '0;
            r_hit  <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_state_nxt == ST_CHECK) begin
                        r_addr <= bus.mem_addr;
                        r_we   <= bus.mem_we;
                    end
                end
                ST_CHECK: begin
                    r_hit <= w_hit;
                    r_err <= 1'b0;
                    r_cnt <= '0;
                end
                ST_ENC: begin
                    // An ack coinciding with expiry still counts as success
                    if (bus.enc_ack) begin
                        r_err <= 1'b0;
                    end else if (w_cnt_last) begin
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Configuration: apply in IDLE (clear beats start), otherwise park as pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_low        <= '0;
            r_high       <= '0;
            r_active     <= 1'b0;
            r_err_cfg    <= 1'b0;
            r_pend_start <= 1'b0;
            r_pend_clear <= 1'b0;
            r_pend_heap  <= '0;
            r_pend_stack <= '0;
        end else if (w_idle) begin
            r_pend_start <= 1'b0;
            r_pend_clear <= 1'b0;
            r_err_cfg    <= 1'b0;
            if (w_do_clear) begin
                r_active <= 1'b0;
            end else if (w_do_start) begin
                if (w_st_heap <= w_st_stack) begin
                    r_low    <= w_st_heap;
                    r_high   <= w_st_stack;
                    r_active <= 1'b1;
                end else begin
                    r_err_cfg <= 1'b1;
                end
            end
        end else begin
            r_err_cfg <= 1'b0;
            if (cfg_start) begin
                r_pend_start <= 1'b1;
                r_pend_heap  <= cfg_heap_top;
                r_pend_stack <= cfg_stack_top;
            end
            if (cfg_clear) begin
                r_pend_clear <= 1'b1;
            end
        end
    end

    assign low_bound  = r_low;
    assign high_bound = r_high;
    assign smc_active = r_active;
    assign err_cfg    = r_err_cfg;

endmodule

// File: tb/tb_smc_access_ctrl.sv
// Directed bench for smc_access_ctrl with ENC_TIMEOUT reduced to 8.
module tb_smc_access_ctrl;
    import smc_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        cfg_start;
    logic [31:0] cfg_stack_top;
    logic [31:0] cfg_heap_top;
    logic        cfg_clear;
    logic [31:0] low_bound;
    logic [31:0] high_bound;
    logic        smc_active;
    logic        err_cfg;

    int n_checks = 0;
    int n_fail   = 0;

    smc_access_ctrl_if #(.AW(32)) bus ();

    smc_access_ctrl #(
        .AW          (32),
        .ENC_TIMEOUT (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_start     (cfg_start),
        .cfg_stack_top (cfg_stack_top),
        .cfg_heap_top  (cfg_heap_top),
        .cfg_clear     (cfg_clear),
        .bus           (bus.slave),
        .low_bound     (low_bound),
        .high_bound    (high_bound),
        .smc_active    (smc_active),
        .err_cfg       (err_cfg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // One-cycle configuration pulse; returns at the negedge after it was sampled
    task automatic cfg(input logic [31:0] heap, input logic [31:0] stack, input logic clr, input logic st);
        cfg_heap_top  = heap;
        cfg_stack_top = stack;
        cfg_start     = st;
        cfg_clear     = clr;
        @(negedge clk);
        cfg_start = 1'b0;
        cfg_clear = 1'b0;
    endtask

    // Issue one access (called at a negedge in IDLE) and check its completion.
    // ack_at: enc_req cycle on which enc_ack is returned (0 = never).
    // inj: pulse cfg_start 0x3000..0x3FFF on the first enc_req cycle.
    task automatic access(input logic [31:0] addr, input logic we, input int ack_at, input bit inj,
                          input logic exp_hit, input logic exp_err, input int exp_lat, input int exp_enc);
        int lat  = 0;
        int nenc = 0;
        bit got  = 1'b0;
        bus.mem_req  = 1'b1;
        bus.mem_addr = addr;
        bus.mem_we   = we;
        #1 chk("stall_on_req", bus.mem_stall, 1'b1);
        while (!got && lat < 40) begin
            @(negedge clk);
            bus.enc_ack = 1'b0;
            if (inj && cfg_start) begin
                cfg_start     = 1'b0;
                cfg_heap_top  = 32'h0000_7000;
                cfg_stack_top = 32'h0000_7FFF;
            end
            lat++;
            if (bus.mem_ack) begin
                got = 1'b1;
                chk("mem_hit", bus.mem_hit, exp_hit);
                chk("mem_err", bus.mem_err, exp_err);
                chk("stall_done", bus.mem_stall, 1'b0);
            end else begin
                chk("stall_busy", bus.mem_stall, 1'b1);
                if (bus.enc_req) begin
                    nenc++;
                    chk("enc_addr", bus.enc_addr, addr);
                    chk("enc_we", bus.enc_we, we);
                    if (nenc == ack_at) bus.enc_ack = 1'b1;
                    if (inj && nenc == 1) begin
                        cfg_start     = 1'b1;
                        cfg_heap_top  = 32'h0000_3000;
                        cfg_stack_top = 32'h0000_3FFF;
                    end
                end
            end
        end
        bus.mem_req = 1'b0;
        bus.enc_ack = 1'b0;
        chk("ack_seen", got, 1'b1);
        chk("latency", lat, exp_lat);
        chk("enc_cycles", nenc, exp_enc);
    endtask

    initial begin
        rst_n         = 1'b0;
        cfg_start     = 1'b0;
        cfg_clear     = 1'b0;
        cfg_stack_top = '0;
        cfg_heap_top  = '0;
        bus.mem_req   = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_we    = 1'b0;
        bus.enc_ack   = 1'b0;

        // Reset values
        #2;
        chk("rst_stall", bus.mem_stall, 1'b0);
        chk("rst_ack", bus.mem_ack, 1'b0);
        chk("rst_enc_req", bus.enc_req, 1'b0);
        chk("rst_enc_addr", bus.enc_addr, 32'h0);
        chk("rst_active", smc_active, 1'b0);
        chk("rst_low", low_bound, 32'h0);
        chk("rst_high", high_bound, 32'h0);
        chk("rst_err_cfg", err_cfg, 1'b0);
        bus.mem_req = 1'b1;
        #1 chk("rst_stall_req", bus.mem_stall, 1'b1);
        bus.mem_req = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Load bounds 0x1000..0x1FFF
        cfg(32'h1000, 32'h1FFF, 1'b0, 1'b1);
        chk("cfg1_active", smc_active, 1'b1);
        chk("cfg1_low", low_bound, 32'h1000);
        chk("cfg1_high", high_bound, 32'h1FFF);
        chk("cfg1_err", err_cfg, 1'b0);

        // Edge reads around the bounds
        access(32'h0FFF, 1'b0, 0, 1'b0, 1'b0, 1'b0, 2, 0); step();
        access(32'h1000, 1'b0, 1, 1'b0, 1'b1, 1'b0, 3, 1); step();
        access(32'h1FFF, 1'b0, 1, 1'b0, 1'b1, 1'b0, 3, 1); step();
        access(32'h2000, 1'b0, 0, 1'b0, 1'b0, 1'b0, 2, 0); step();

        // Write hit, engine answers on the fifth request cycle
        access(32'h1800, 1'b1, 5, 1'b0, 1'b1, 1'b0, 7, 5); step();

        // Engine never answers: timeout after 8 request cycles, then normal access
        access(32'h1000, 1'b0, 0, 1'b0, 1'b1, 1'b1, 10, 8); step();
        access(32'h1004, 1'b0, 2, 1'b0, 1'b1, 1'b0, 4, 2); step();

        // Ack on the expiry cycle counts as success
        access(32'h1FFE, 1'b1, 8, 1'b0, 1'b1, 1'b0, 10, 8); step();

        // Stray enc_ack while idle must not shorten the next engine wait
        bus.enc_ack = 1'b1; step(); bus.enc_ack = 1'b0;
        access(32'h1000, 1'b0, 3, 1'b0, 1'b1, 1'b0, 5, 3); step();

        // cfg_start during ENC: old bounds for this access, new bounds afterwards
        access(32'h1800, 1'b0, 3, 1'b1, 1'b1, 1'b0, 5, 3);
        chk("pend_low_kept", low_bound, 32'h1000);
        step();
        access(32'h3000, 1'b0, 1, 1'b0, 1'b1, 1'b0, 4, 1);
        chk("pend_low_new", low_bound, 32'h3000);
        chk("pend_high_new", high_bound, 32'h3FFF);
        step();
        access(32'h1800, 1'b0, 0, 1'b0, 1'b0, 1'b0, 2, 0); step();

        // Rejected configuration
        cfg(32'h5000, 32'h4000, 1'b0, 1'b1);
        chk("bad_err_cfg", err_cfg, 1'b1);
        chk("bad_low", low_bound, 32'h3000);
        chk("bad_high", high_bound, 32'h3FFF);
        chk("bad_active", smc_active, 1'b1);
        step();
        chk("err_cfg_pulse", err_cfg, 1'b0);

        // Start and clear together: clear wins
        cfg(32'h6000, 32'h6FFF, 1'b1, 1'b1);
        chk("clr_active", smc_active, 1'b0);
        chk("clr_low", low_bound, 32'h3000);
        chk("clr_err_cfg", err_cfg, 1'b0);
        access(32'h3000, 1'b0, 0, 1'b0, 1'b0, 1'b0, 2, 0); step();

        // Single-address window
        cfg(32'h8000, 32'h8000, 1'b0, 1'b1);
        chk("eq_active", smc_active, 1'b1);
        access(32'h8000, 1'b0, 1, 1'b0, 1'b1, 1'b0, 3, 1); step();

        // Reset in the middle of ENC
        bus.mem_req  = 1'b1;
        bus.mem_addr = 32'h8000;
        bus.mem_we   = 1'b1;
        step(); step();
        chk("pre_rst_enc_req", bus.enc_req, 1'b1);
        bus.mem_req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_enc_req", bus.enc_req, 1'b0);
        chk("mid_rst_stall", bus.mem_stall, 1'b0);
        chk("mid_rst_ack", bus.mem_ack, 1'b0);
        chk("mid_rst_enc_addr", bus.enc_addr, 32'h0);
        chk("mid_rst_enc_we", bus.enc_we, 1'b0);
        chk("mid_rst_active", smc_active, 1'b0);
        chk("mid_rst_low", low_bound, 32'h0);
        repeat (2) begin
            step();
            chk("rst_no_ack", bus.mem_ack, 1'b0);
        end
        rst_n = 1'b1;
        repeat (3) begin
            step();
            chk("post_rst_no_ack", bus.mem_ack, 1'b0);
            chk("post_rst_active", smc_active, 1'b0);
        end
        access(32'h8000, 1'b0, 0, 1'b0, 1'b0, 1'b0, 2, 0); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
